// File: rtl/object_line_prefetcher_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mapache64 : shared types for the object line prefetcher              |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mapache64;

   typedef struct packed {
      logic [1:0] lightness;
      logic [2:0] color;
   } pixel_t;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [4:0] pmfa;
      logic [2:0] color;
      logic       hflip;
      logic       vflip;
   } obm_object_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SCAN  = 2'd2,
      DRAW  = 2'd3
   } state_e;

   localparam int LINE_W   = 256;
   localparam int OBJ_ROWS = 8;

   // Pixel 0 sits in the top two bits of a pattern line.
   function automatic logic [1:0] pmf_pixel(input logic [15:0] line, input logic [2:0] col);
      logic [15:0] shifted;
      shifted = line << {col, 1'b0};
      return shifted[15:14];
   endfunction

endpackage
`default_nettype wire

// File: rtl/object_line_prefetcher_scanline_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scanline_buffer : 256-pixel line store with a {valid, y} tag         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scanline_buffer
   import mapache64::*;
(
   input  logic       gpu_clk,
   input  logic       rst,
   input  logic       wr_en_i,
   input  logic [7:0] wr_x_i,
   input  pixel_t     wr_pixel_i,
   input  logic [7:0] rd_x_i,
   output pixel_t     rd_pixel_o,
   input  logic       tag_clr_i,
   input  logic       tag_set_i,
   input  logic [7:0] tag_y_i,
   output logic       tag_valid_o,
   output logic [7:0] tag_y_o
);

   pixel_t     mem_q [LINE_W];
   logic       tag_valid_q, tag_valid_d;
   logic [7:0] tag_y_q, tag_y_d;

   always_ff @(posedge gpu_clk) begin
      if (wr_en_i) begin
         mem_q[wr_x_i] <= wr_pixel_i;
      end
   end

   assign rd_pixel_o = mem_q[rd_x_i];

   always_comb begin
      tag_valid_d = tag_valid_q;
      tag_y_d     = tag_y_q;
      if (tag_clr_i) begin
         tag_valid_d = 1'b0;
      end
      if (tag_set_i) begin
         tag_valid_d = 1'b1;
         tag_y_d     = tag_y_i;
      end
   end

   always_ff @(posedge gpu_clk) begin
      if (rst) begin
         tag_valid_q <= 1'b0;
         tag_y_q     <= 8'd0;
      end else begin
         tag_valid_q <= tag_valid_d;
         tag_y_q     <= tag_y_d;
      end
   end

   assign tag_valid_o = tag_valid_q;
   assign tag_y_o     = tag_y_q;

endmodule
`default_nettype wire

// File: rtl/object_line_prefetcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | object_line_prefetcher : builds object scanlines into ring buffers   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module object_line_prefetcher
   import mapache64::*;
#(
   parameter int NUM_OBJECTS  = 64,
   parameter int NUM_BUFS     = 2,
   parameter int MAX_PER_LINE = 8
) (
   input  logic                           gpu_clk,
   input  logic                           rst,
   input  logic                           prefetch_start_i,
   input  logic [7:0]                     prefetch_y_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           drop_o,
   output logic                           overflow_o,
   output logic [$clog2(NUM_OBJECTS)-1:0] obm_index_o,
   input  obm_object_t                    obm_object_i,
   output logic [7:0]                     pmf_addr_o,
   input  logic [15:0]                    pmf_line_i,
   input  logic [7:0]                     display_x_i,
   input  logic [7:0]                     display_y_i,
   output logic [1:0]                     r_o,
   output logic [1:0]                     g_o,
   output logic [1:0]                     b_o,
   output logic                           valid_o
);

   localparam int IW = $clog2(NUM_OBJECTS);
   localparam int BW = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
   localparam int HW = $clog2(MAX_PER_LINE + 1);
   localparam int PW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

   state_e         state_q, state_d;
   logic [7:0]     x_q, x_d;
   logic [IW-1:0]  obj_q, obj_d;
   logic [HW-1:0]  hit_cnt_q, hit_cnt_d;
   logic [IW-1:0]  hit_idx_q [MAX_PER_LINE];
   logic [IW-1:0]  hit_idx_d [MAX_PER_LINE];
   logic [2:0]     hit_row_q [MAX_PER_LINE];
   logic [2:0]     hit_row_d [MAX_PER_LINE];
   logic [PW-1:0]  ptr_q, ptr_d;
   logic [2:0]     col_q, col_d;
   logic [BW-1:0]  rr_q, rr_d;
   logic [BW-1:0]  tgt_q, tgt_d;
   logic [7:0]     y_q, y_d;
   logic           overflow_q, overflow_d;
   logic           done_q, done_d;
   logic [1:0]     r_q, r_d, g_q, g_d, b_q, b_d;
   logic           valid_q, valid_d;

   logic           wr_en, tag_clr, tag_set;
   logic [7:0]     wr_x;
   pixel_t         wr_pix;
   logic [8:0]     scan_diff, draw_x;
   logic           scan_hit;
   logic [2:0]     cur_row, eff_row, eff_col;
   logic [1:0]     light;

   pixel_t         rd_pix    [NUM_BUFS];
   logic           tag_valid [NUM_BUFS];
   logic [7:0]     tag_y     [NUM_BUFS];
   pixel_t         disp_pix;
   logic           disp_hit;

   // Unsigned 9-bit difference: objects below the line wrap to large values and miss.
   assign scan_diff = {1'b0, y_q} - {1'b0, obm_object_i.y};
   assign scan_hit  = (scan_diff <= 9'd7);

   assign cur_row = hit_row_q[ptr_q];
   assign eff_row = obm_object_i.vflip ? ~cur_row : cur_row;
   assign eff_col = obm_object_i.hflip ? ~col_q : col_q;
   assign light   = pmf_pixel(pmf_line_i, eff_col);
   assign draw_x  = {1'b0, obm_object_i.x} + {6'd0, col_q};

   assign obm_index_o = (state_q == DRAW) ? hit_idx_q[ptr_q] : obj_q;
   assign pmf_addr_o  = {obm_object_i.pmfa, eff_row};

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      obj_d      = obj_q;
      hit_cnt_d  = hit_cnt_q;
      hit_idx_d  = hit_idx_q;
      hit_row_d  = hit_row_q;
      ptr_d      = ptr_q;
      col_d      = col_q;
      rr_d       = rr_q;
      tgt_d      = tgt_q;
      y_d        = y_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      wr_en      = 1'b0;
      wr_x       = x_q;
      wr_pix     = '0;
      tag_clr    = 1'b0;
      tag_set    = 1'b0;

      case (state_q)
         IDLE: begin
            if (prefetch_start_i) begin
               state_d    = CLEAR;
               tgt_d      = rr_q;
               rr_d       = (rr_q == BW'(NUM_BUFS - 1)) ? '0 : rr_q + 1'b1;
               y_d        = prefetch_y_i;
               overflow_d = 1'b0;
               x_d        = 8'd0;
               tag_clr    = 1'b1;
            end
         end
         CLEAR: begin
            wr_en = 1'b1;
            x_d   = x_q + 8'd1;
            if (x_q == 8'd255) begin
               state_d   = SCAN;
               obj_d     = '0;
               hit_cnt_d = '0;
            end
         end
         SCAN: begin
            if (scan_hit) begin
               if (hit_cnt_q < HW'(MAX_PER_LINE)) begin
                  for (int i = 0; i < MAX_PER_LINE; i++) begin
                     if (hit_cnt_q == HW'(i)) begin
                        hit_idx_d[i] = obj_q;
                        hit_row_d[i] = scan_diff[2:0];
                     end
                  end
                  hit_cnt_d = hit_cnt_q + 1'b1;
               end else begin
                  overflow_d = 1'b1;
               end
            end
            if (obj_q == IW'(NUM_OBJECTS - 1)) begin
               if (hit_cnt_d == '0) begin
                  state_d = IDLE;
                  tag_set = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  state_d = DRAW;
                  ptr_d   = PW'(hit_cnt_d - 1'b1);
                  col_d   = 3'd0;
               end
            end else begin
               obj_d = obj_q + 1'b1;
            end
         end
         DRAW: begin
            wr_en            = (light != 2'd0) && !draw_x[8];
            wr_x             = draw_x[7:0];
            wr_pix.lightness = light;
            wr_pix.color     = obm_object_i.color;
            col_d            = col_q + 3'd1;
            if (col_q == 3'd7) begin
               if (ptr_q == '0) begin
                  state_d = IDLE;
                  tag_set = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  ptr_d = ptr_q - 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge gpu_clk) begin
      if (rst) begin
         state_q    <= IDLE;
         x_q        <= 8'd0;
         obj_q      <= '0;
         hit_cnt_q  <= '0;
         ptr_q      <= '0;
         col_q      <= 3'd0;
         rr_q       <= '0;
         tgt_q      <= '0;
         y_q        <= 8'd0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         obj_q      <= obj_d;
         hit_cnt_q  <= hit_cnt_d;
         ptr_q      <= ptr_d;
         col_q      <= col_d;
         rr_q       <= rr_d;
         tgt_q      <= tgt_d;
         y_q        <= y_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge gpu_clk) begin
      hit_idx_q <= hit_idx_d;
      hit_row_q <= hit_row_d;
   end

   // The buffer under construction has its tag cleared, so it never matches a display read.
   for (genvar g = 0; g < NUM_BUFS; g++) begin : g_buf
      scanline_buffer u_buf (
         .gpu_clk     (gpu_clk),
         .rst         (rst),
         .wr_en_i     (wr_en && (tgt_q == BW'(g))),
         .wr_x_i      (wr_x),
         .wr_pixel_i  (wr_pix),
         .rd_x_i      (display_x_i),
         .rd_pixel_o  (rd_pix[g]),
         .tag_clr_i   (tag_clr && (rr_q == BW'(g))),
         .tag_set_i   (tag_set && (tgt_q == BW'(g))),
         .tag_y_i     (y_q),
         .tag_valid_o (tag_valid[g]),
         .tag_y_o     (tag_y[g])
      );
   end

   always_comb begin
      disp_pix = '0;
      disp_hit = 1'b0;
      for (int i = NUM_BUFS - 1; i >= 0; i--) begin
         if (tag_valid[i] && (tag_y[i] == display_y_i)) begin
            disp_hit = 1'b1;
            disp_pix = rd_pix[i];
         end
      end
      r_d     = disp_hit ? (disp_pix.lightness & {2{disp_pix.color[2]}}) : 2'd0;
      g_d     = disp_hit ? (disp_pix.lightness & {2{disp_pix.color[1]}}) : 2'd0;
      b_d     = disp_hit ? (disp_pix.lightness & {2{disp_pix.color[0]}}) : 2'd0;
      valid_d = disp_hit && (disp_pix.lightness != 2'd0);
   end

   always_ff @(posedge gpu_clk) begin
      if (rst) begin
         r_q     <= 2'd0;
         g_q     <= 2'd0;
         b_q     <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         valid_q <= valid_d;
      end
   end

   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;
   assign drop_o     = prefetch_start_i && (state_q != IDLE) && !rst;
   assign overflow_o = overflow_q;
   assign r_o        = r_q;
   assign g_o        = g_q;
   assign b_o        = b_q;
   assign valid_o    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_object_line_prefetcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_object_line_prefetcher : directed self-checking bench             |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_object_line_prefetcher;
   import mapache64::*;

   logic        gpu_clk = 1'b0;
   logic        rst;
   logic        prefetch_start_i;
   logic [7:0]  prefetch_y_i;
   logic        busy_o, done_o, drop_o, overflow_o;
   logic [5:0]  obm_index_o;
   obm_object_t obm_object_i;
   logic [7:0]  pmf_addr_o;
   logic [15:0] pmf_line_i;
   logic [7:0]  display_x_i, display_y_i;
   logic [1:0]  r_o, g_o, b_o;
   logic        valid_o;

   obm_object_t obm [64];
   logic [15:0] pmf [256];

   int total = 0;
   int bad   = 0;

   always #5 gpu_clk = ~gpu_clk;

   assign obm_object_i = obm[obm_index_o];
   assign pmf_line_i   = pmf[pmf_addr_o];

   object_line_prefetcher #(
      .NUM_OBJECTS  (64),
      .NUM_BUFS     (2),
      .MAX_PER_LINE (8)
   ) dut (
      .gpu_clk          (gpu_clk),
      .rst              (rst),
      .prefetch_start_i (prefetch_start_i),
      .prefetch_y_i     (prefetch_y_i),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .drop_o           (drop_o),
      .overflow_o       (overflow_o),
      .obm_index_o      (obm_index_o),
      .obm_object_i     (obm_object_i),
      .pmf_addr_o       (pmf_addr_o),
      .pmf_line_i       (pmf_line_i),
      .display_x_i      (display_x_i),
      .display_y_i      (display_y_i),
      .r_o              (r_o),
      .g_o              (g_o),
      .b_o              (b_o),
      .valid_o          (valid_o)
   );

   task automatic tick;
      @(posedge gpu_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_objs;
      for (int i = 0; i < 64; i++) begin
         obm[i] = '{x: 8'd0, y: 8'd200, pmfa: 5'd0, color: 3'd0, hflip: 1'b0, vflip: 1'b0};
      end
   endtask

   task automatic set_obj(input int idx, input logic [7:0] x, input logic [7:0] y,
                          input logic [4:0] pmfa, input logic [2:0] color,
                          input logic hf, input logic vf);
      obm[idx] = '{x: x, y: y, pmfa: pmfa, color: color, hflip: hf, vflip: vf};
   endtask

   task automatic wait_done(input string tag);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         tick();
         if (done_o) seen = 1'b1;
      end
      check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      check({tag, "_idle_at_done"}, {31'd0, busy_o}, 32'd0);
      tick();
      check({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
   endtask

   task automatic build(input string tag, input logic [7:0] y);
      prefetch_y_i     = y;
      prefetch_start_i = 1'b1;
      tick();
      prefetch_start_i = 1'b0;
      check({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
      wait_done(tag);
   endtask

   task automatic pix(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic v, input logic [1:0] r, input logic [1:0] g, input logic [1:0] b);
      display_x_i = x;
      display_y_i = y;
      tick();
      check(tag, {25'd0, valid_o, r_o, g_o, b_o}, {25'd0, v, r, g, b});
   endtask

   initial begin
      int cnt;
      rst              = 1'b1;
      prefetch_start_i = 1'b0;
      prefetch_y_i     = 8'd0;
      display_x_i      = 8'd0;
      display_y_i      = 8'd0;
      clear_objs();
      for (int i = 0; i < 256; i++) pmf[i] = 16'h0000;
      for (int i = 8; i < 16; i++) pmf[i] = 16'hFFFF;
      for (int i = 16; i < 24; i++) pmf[i] = 16'h00FF;
      for (int i = 24; i < 32; i++) pmf[i] = 16'hC000;

      tick();
      tick();
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_overflow", {31'd0, overflow_o}, 32'd0);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_rgb", {26'd0, r_o, g_o, b_o}, 32'd0);
      rst = 1'b0;
      tick();

      // Basic red object at (10,20)
      set_obj(0, 8'd10, 8'd20, 5'd1, 3'b100, 1'b0, 1'b0);
      build("basic", 8'd20);
      for (int x = 10; x <= 17; x++) pix("basic_px", 8'(x), 8'd20, 1'b1, 2'd3, 2'd0, 2'd0);
      pix("basic_x9", 8'd9, 8'd20, 1'b0, 2'd0, 2'd0, 2'd0);
      pix("basic_x18", 8'd18, 8'd20, 1'b0, 2'd0, 2'd0, 2'd0);
      pix("basic_other_y", 8'd12, 8'd21, 1'b0, 2'd0, 2'd0, 2'd0);

      // Vertical flip: row 0 of pattern has lightness 1
      pmf[8] = 16'h5555;
      set_obj(0, 8'd10, 8'd20, 5'd1, 3'b100, 1'b0, 1'b1);
      build("vflip", 8'd27);
      pix("vflip_x10", 8'd10, 8'd27, 1'b1, 2'd1, 2'd0, 2'd0);
      pix("vflip_x17", 8'd17, 8'd27, 1'b1, 2'd1, 2'd0, 2'd0);
      build("below", 8'd28);
      cnt = 0;
      for (int x = 0; x < 256; x++) begin
         display_x_i = 8'(x);
         display_y_i = 8'd28;
         tick();
         if (valid_o) cnt++;
      end
      check("below_line_empty", 32'(cnt), 32'd0);
      pmf[8] = 16'hFFFF;

      // Horizontal flip: only pattern column 0 opaque, lands at x=17
      set_obj(0, 8'd10, 8'd20, 5'd3, 3'b010, 1'b1, 1'b0);
      build("hflip", 8'd20);
      pix("hflip_x17", 8'd17, 8'd20, 1'b1, 2'd0, 2'd3, 2'd0);
      pix("hflip_x10", 8'd10, 8'd20, 1'b0, 2'd0, 2'd0, 2'd0);

      // Ten objects on one line, limit 8
      clear_objs();
      for (int i = 0; i < 10; i++) set_obj(i, 8'(12 * i), 8'd50, 5'd1, 3'b001, 1'b0, 1'b0);
      build("ovf", 8'd50);
      check("ovf_flag", {31'd0, overflow_o}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (i < 8) pix("ovf_drawn", 8'(12 * i), 8'd50, 1'b1, 2'd0, 2'd0, 2'd3);
         else       pix("ovf_absent", 8'(12 * i), 8'd50, 1'b0, 2'd0, 2'd0, 2'd0);
      end

      // Overlap priority plus a dropped request mid-build
      clear_objs();
      set_obj(3, 8'd100, 8'd60, 5'd2, 3'b100, 1'b0, 1'b0);
      set_obj(5, 8'd100, 8'd60, 5'd1, 3'b010, 1'b0, 1'b0);
      prefetch_y_i     = 8'd60;
      prefetch_start_i = 1'b1;
      tick();
      prefetch_start_i = 1'b0;
      check("ovl_overflow_cleared", {31'd0, overflow_o}, 32'd0);
      repeat (10) tick();
      prefetch_y_i     = 8'd99;
      prefetch_start_i = 1'b1;
      #1;
      check("drop_pulse", {31'd0, drop_o}, 32'd1);
      tick();
      prefetch_start_i = 1'b0;
      #1;
      check("drop_gone", {31'd0, drop_o}, 32'd0);
      check("drop_still_busy", {31'd0, busy_o}, 32'd1);
      wait_done("ovl");
      pix("ovl_x101_obj5", 8'd101, 8'd60, 1'b1, 2'd0, 2'd3, 2'd0);
      pix("ovl_x105_obj3", 8'd105, 8'd60, 1'b1, 2'd3, 2'd0, 2'd0);
      pix("ovl_x108", 8'd108, 8'd60, 1'b0, 2'd0, 2'd0, 2'd0);
      pix("ovl_dropped_y", 8'd101, 8'd99, 1'b0, 2'd0, 2'd0, 2'd0);

      // Right edge, no wrap
      clear_objs();
      set_obj(0, 8'd252, 8'd70, 5'd1, 3'b111, 1'b0, 1'b0);
      build("edge", 8'd70);
      pix("edge_x252", 8'd252, 8'd70, 1'b1, 2'd3, 2'd3, 2'd3);
      pix("edge_x255", 8'd255, 8'd70, 1'b1, 2'd3, 2'd3, 2'd3);
      pix("edge_x0", 8'd0, 8'd70, 1'b0, 2'd0, 2'd0, 2'd0);
      pix("edge_x3", 8'd3, 8'd70, 1'b0, 2'd0, 2'd0, 2'd0);

      // Reset in the middle of DRAW
      prefetch_y_i     = 8'd70;
      prefetch_start_i = 1'b1;
      tick();
      prefetch_start_i = 1'b0;
      repeat (323) tick();
      check("middraw_busy", {31'd0, busy_o}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
      check("rst_mid_done", {31'd0, done_o}, 32'd0);
      cnt = 0;
      for (int y = 0; y < 256; y++) begin
         display_x_i = 8'd252;
         display_y_i = 8'(y);
         tick();
         if (valid_o) cnt++;
      end
      check("rst_mid_no_valid", 32'(cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/object_line_prefetcher.md
OBJECT_LINE_PREFETCHER -- requirements
Module: object_line_prefetcher

Interface
REQ-001 SHALL have parameter NUM_OBJECTS, default 64: number of objects in object memory (power of 2, 2..256).
REQ-002 SHALL have parameter NUM_BUFS, default 2: number of scanline buffers (2..4).
REQ-003 SHALL have parameter MAX_PER_LINE, default 8: object hits drawn per scanline (1..NUM_OBJECTS).
REQ-004 SHALL have port gpu_clk  in  1: the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have port prefetch_start_i  in  1: one-cycle request to build the line prefetch_y_i.
REQ-007 SHALL have port prefetch_y_i  in  8: scanline to build, sampled with prefetch_start_i.
REQ-008 SHALL have ports busy_o, done_o, drop_o, overflow_o  out  1 each: engine active, completion pulse, rejected-request pulse, hit-limit-exceeded flag for the last built line.
REQ-009 SHALL have port obm_index_o  out  clog2(NUM_OBJECTS), and port obm_object_i  in  mapache64::obm_object_t, returned combinationally in the same cycle.
REQ-010 SHALL have port pmf_addr_o  out  8 ({pmfa, row}), and port pmf_line_i  in  16, returned combinationally (pixel 0 in bits 15:14).
REQ-011 SHALL have ports display_x_i, display_y_i  in  8 each, and outputs r_o, g_o, b_o  out  2 each, plus valid_o  out  1.

Function
REQ-012 SHALL use FSM states IDLE, CLEAR, SCAN, DRAW; IDLE->CLEAR on prefetch_start_i; CLEAR->SCAN after 256 cycles; SCAN->DRAW after NUM_OBJECTS cycles; DRAW->IDLE after 8 cycles per stored hit (0 hits: SCAN->IDLE directly).
REQ-013 SHALL, on accept, select the target buffer round-robin (wraps NUM_BUFS-1 -> 0), invalidate its tag, and latch prefetch_y_i.
REQ-014 CLEAR SHALL write a transparent pixel (lightness 0) to one buffer entry per cycle, x = 0..255.
REQ-015 SCAN SHALL examine one object per cycle in index order 0..NUM_OBJECTS-1; hit when 0 <= y - obj.y <= 7, computed in 9-bit unsigned (no vertical wrap).
REQ-016 SHALL store the first MAX_PER_LINE hits (index and row = y - obj.y); any further hit sets overflow_o, which holds until the next accept clears it.
REQ-017 DRAW SHALL process stored hits from last to first, one pixel per cycle, row flipped when vflip and column flipped when hflip, so a lower object index overwrites a higher one.
REQ-018 DRAW SHALL write a pixel only if its lightness is nonzero and obj.x + col <= 255 (no horizontal wrap).
REQ-019 On completion SHALL set the buffer tag to {valid, y} and pulse done_o for one cycle.
REQ-020 busy_o SHALL be 1 in every state other than IDLE.
REQ-021 prefetch_start_i while busy_o SHALL be ignored and SHALL pulse drop_o in the same cycle.
REQ-022 Display SHALL read the buffer whose valid tag equals display_y_i; if none, valid_o=0; lowest buffer index wins if several match.
REQ-023 Display outputs SHALL be registered (latency 1 cycle): r/g/b = lightness AND {2{color bit 2/1/0}}, valid_o = (lightness != 0).
REQ-024 A buffer being built SHALL never be displayed; a read and a write to different buffers in one cycle SHALL both proceed.

Reset
REQ-025 rst SHALL force IDLE, invalidate all tags, clear the round-robin pointer, and set busy_o, done_o, drop_o, overflow_o and valid_o to 0; mid-operation builds are abandoned.
REQ-026 r/g/b outputs SHALL reset to 0; buffer pixel contents need not reset.

Structure
REQ-027 pixel_t, obm_object_t and the FSM state enum SHALL live in package mapache64; parameters stay local.
REQ-028 Each line buffer SHALL be an instance of sub-module scanline_buffer (256 x pixel_t, one write port, one read port, tag register).

Verification
REQ-029 Object 0 at (x=10, y=20), pattern all lightness 3, color 3'b100; build y=20 -> after done_o, display y=20, x=10..17 gives r=3, g=b=0; x=18 gives valid_o=0.
REQ-030 Build y=27 with the same object and vflip -> pixels come from pattern row 0; build y=28 -> valid_o=0 across the line.
REQ-031 Ten objects all hit y=50, MAX_PER_LINE=8 -> objects 0..7 drawn, 8..9 absent, overflow_o=1.
REQ-032 Objects 3 and 5 overlap at x=100 -> object 3's color is shown; object 5 is visible only where object 3 is transparent.
REQ-033 Object at x=252 -> x=252..255 drawn, nothing at x=0..3.
REQ-034 A second prefetch_start_i while busy -> drop_o pulse and no state change; rst mid-DRAW -> IDLE, valid_o=0 for every display_y.
